seq_multiplier: RTL

//  Parametrised iterative radix-2 shift-add multiplier for the LEGv8 datapath (MUL/SMULH/UMULH).

---
 rtl/seq_multiplier.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier with a valid/ready
// handshake on both the operand and the product side. Operands are reduced
// to magnitudes at accept, multiplied unsigned one bit per cycle, and the
// sign is applied once the last iteration has finished.
//
// Optional build macro EARLY_TERM_EN: stop iterating as soon as the remaining
// multiplier bits are all zero. The partial {acc,mult} is then realigned by
// the number of skipped iterations, so the product equals that of a full run.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one shift-add iteration per cycle, then finalize
// DONE  | product presented with out_valid=1 until consumed

module seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mult;
   logic               sign;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] mag;
   logic               finalize;

`ifdef EARLY_TERM_EN
   logic               last;
   logic [WIDTH-2:0]   rem;
`endif

   // Operand magnitudes and the per-iteration adder (carry kept in sum[WIDTH])
   always_comb begin
      mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
      mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
      sum   = {1'b0, acc} + (mult[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`ifdef EARLY_TERM_EN
      // cnt holds the iterations that were skipped; shift the result back into place
      mag      = {acc, mult} >> cnt;
      finalize = (cnt == '0) || last;
`else
      mag      = {acc, mult};
      finalize = (cnt == '0);
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
         S_BUSY:  if (finalize)  state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      busy      = (state == S_BUSY);
   end

   // Datapath: latch operands, iterate with a down-counter, apply sign at the end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc     <= '0;
         mult    <= '0;
         sign    <= 1'b0;
         cnt     <= '0;
         product <= '0;
`ifdef EARLY_TERM_EN
         last    <= 1'b0;
         rem     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mcand <= mag_a;
                  mult  <= mag_b;
                  acc   <= '0;
                  sign  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  cnt   <= CNT_INIT;
`ifdef EARLY_TERM_EN
                  last  <= 1'b0;
                  rem   <= mag_b[WIDTH-1:1];
`endif
               end
            end
            S_BUSY: begin
               if (finalize) begin
                  product <= sign ? -mag : mag;
               end else begin
                  acc  <= sum[WIDTH:1];
                  mult <= {sum[0], mult[WIDTH-1:1]};
                  cnt  <= cnt - 1'b1;
`ifdef EARLY_TERM_EN
                  // rem holds the multiplier bits still to be processed after this one
                  last <= (rem == '0);
                  rem  <= rem >> 1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
